// File: rtl/load_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : load_result_serializer
// Captures changed load results into a word FIFO; streams each word MSB byte first.
// Revision : 1.0
// ============================================================================
module load_result_serializer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             capture_en,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow,
    output logic             busy
);
    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = DEPTH[c_AW:0];

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;

    logic [WIDTH-1:0] prev_q;
    logic             primed_q;
    logic             overflow_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]    count_q;

    logic             w_cap_req;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // The first enabled sample after reset is always captured, even when zero.
    assign w_cap_req = capture_en & ((result != prev_q) | ~primed_q);
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_DEPTH);
    assign w_push    = w_cap_req & (~w_full | w_pop);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == 3'd7) begin
                        // Chain straight into the next word so the stream has no bubble.
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            idx_d   = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        shift_d = shift_q << 8;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            prev_q <= result;
            if (w_cap_req) begin
                primed_q <= 1'b1;
            end
            if (w_cap_req && !w_push) begin
                overflow_q <= 1'b1;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign out_data  = shift_q[WIDTH-1 -: 8];
    assign out_valid = (state_q == S_SEND);
    assign out_last  = (state_q == S_SEND) && (idx_q == 3'd7);
    assign overflow  = overflow_q;
    assign busy      = !w_empty || (state_q == S_SEND);

endmodule
`default_nettype wire

// File: tb/tb_load_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_result_serializer
// Queue-based reference model with per-cycle compare, directed and random stimulus.
// Revision : 1.0
// ============================================================================
module tb_load_result_serializer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] result;
    logic        capture_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [7:0] obs_b[$];
    logic       obs_l[$];
    int         obs_c[$];

    load_result_serializer #(.DEPTH(DEPTH), .WIDTH(64)) dut (
        .clk(clk), .rst(rst), .result(result), .capture_en(capture_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: pending words, the word being sent and its byte position.
    logic [63:0] m_q[$];
    logic [63:0] m_cur;
    logic [63:0] m_prev;
    int          m_idx;
    bit          m_sending, m_primed, m_ovf;

    always @(posedge clk or posedge rst) begin : model
        int sz;
        bit req, pop;
        if (rst) begin
            m_q.delete();
            m_cur = '0; m_prev = '0; m_idx = 0;
            m_sending = 0; m_primed = 0; m_ovf = 0;
        end else begin
            sz  = m_q.size();
            req = capture_en && (!m_primed || result != m_prev);
            pop = 0;
            if (!m_sending) begin
                if (sz > 0) begin
                    m_cur = m_q.pop_front(); m_idx = 0; m_sending = 1; pop = 1;
                end
            end else if (out_ready) begin
                if (m_idx == 7) begin
                    if (sz > 0) begin
                        m_cur = m_q.pop_front(); m_idx = 0; pop = 1;
                    end else begin
                        m_sending = 0;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (req) begin
                if (sz < DEPTH || pop) m_q.push_back(result);
                else m_ovf = 1;
                m_primed = 1;
            end
            m_prev = result;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] ed;
        bit ev, el, eb;
        cyc++;
        if (chk_en) begin
            ev = m_sending;
            el = m_sending && (m_idx == 7);
            eb = m_sending || (m_q.size() != 0);
            ed = m_cur[63 - 8*m_idx -: 8];
            tests++;
            if (out_valid !== ev || out_last !== el || overflow !== m_ovf ||
                busy !== eb || (ev && out_data !== ed)) begin
                fails++;
                $display("FAIL cycle_check @%0d: got v=%b d=%h l=%b ovf=%b busy=%b, expected v=%b d=%h l=%b ovf=%b busy=%b",
                         cyc, out_valid, out_data, out_last, overflow, busy, ev, ed, el, m_ovf, eb);
            end
            if (out_valid && out_ready && !rst) begin
                obs_b.push_back(out_data);
                obs_l.push_back(out_last);
                obs_c.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clr_obs();
        obs_b.delete(); obs_l.delete(); obs_c.delete();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_b.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (obs_b.size() < n) begin
            tests++; fails++;
            $display("FAIL wait_obs: got %0d bytes, expected %0d", obs_b.size(), n);
        end
    endtask

    function automatic logic lst(input int i);
        return (i < obs_l.size()) ? obs_l[i] : 1'bx;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < obs_c.size()) ? obs_c[i] : -1000;
    endfunction

    function automatic int n_last();
        int n = 0;
        foreach (obs_l[i]) if (obs_l[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic chk_word(input string name, input int base, input logic [63:0] w);
        logic [63:0] a;
        for (int j = 0; j < 8; j++) begin
            a = 'x;
            if (base + j < obs_b.size()) a = {56'd0, obs_b[base + j]};
            chk(name, a, {56'd0, w[63 - 8*j -: 8]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] v[4];
        logic [63:0] pool[4];
        bit pat[4];
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        v   = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};

        rst = 1'b1; capture_en = 1'b0; out_ready = 1'b0; result = '0;
        tick(2);
        chk_en = 1'b1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovf", overflow, 0);
        rst = 1'b0;

        // Primed capture of a constant zero: exactly one word
        capture_en = 1'b1; out_ready = 1'b1; result = '0;
        wait_obs(8, 20); tick(6);
        chk_word("t1_zero_bytes", 0, 64'h0);
        chk("t1_count", obs_b.size(), 8);
        chk("t1_last", lst(7), 1);
        chk("t1_last_only", n_last(), 1);
        chk("t1_busy", busy, 0);

        // Latency and byte order
        clr_obs();
        result = 64'h0123_4567_89AB_CDEF;
        tick(1); chk("t2_lat_e0", out_valid, 0);
        tick(1); chk("t2_lat_e1", out_valid, 1);
        chk("t2_first", out_data, 8'h01);
        wait_obs(8, 20); tick(2);
        chk_word("t2_bytes", 0, 64'h0123_4567_89AB_CDEF);
        chk("t2_last", lst(7), 1);
        chk("t2_contig", cyc_at(7) - cyc_at(0), 7);

        // Back-to-back words stream without a gap
        clr_obs();
        result = 64'hAABB_CCDD_EEFF_0011; tick(1);
        result = 64'h1122_3344_5566_7788;
        wait_obs(16, 40); tick(2);
        chk_word("t3_word_a", 0, 64'hAABB_CCDD_EEFF_0011);
        chk_word("t3_word_b", 8, 64'h1122_3344_5566_7788);
        chk("t3_last8", lst(7), 1);
        chk("t3_last16", lst(15), 1);
        chk("t3_nlast", n_last(), 2);
        chk("t3_contig", cyc_at(15) - cyc_at(0), 15);

        // Stalled consumer: fourth word dropped
        clr_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            result = v[i];
            tick(1);
        end
        tick(2);
        chk("t4_ovf_set", overflow, 1);
        chk("t4_busy", busy, 1);
        out_ready = 1'b1;
        wait_obs(24, 60); tick(4);
        chk_word("t4_w1", 0, v[0]);
        chk_word("t4_w2", 8, v[1]);
        chk_word("t4_w3", 16, v[2]);
        chk("t4_count", obs_b.size(), 24);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_idle", busy, 0);

        // Toggling ready
        clr_obs();
        result = 64'hCAFE_F00D_1234_5678;
        for (int i = 0; i < 48; i++) begin
            out_ready = pat[i % 4];
            tick(1);
        end
        chk_word("t5_bytes", 0, 64'hCAFE_F00D_1234_5678);
        chk("t5_count", obs_b.size(), 8);

        // Reset in the middle of a word
        clr_obs();
        out_ready = 1'b1;
        result = 64'h0F0E_0D0C_0B0A_0908;
        k = 0;
        while (obs_b.size() < 3 && k < 30) begin
            tick(1);
            k++;
        end
        chk("t6_reach", obs_b.size(), 3);
        rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf", overflow, 0);
        tick(2);
        rst = 1'b0;
        clr_obs();
        result = 64'h7766_5544_3322_1100;
        wait_obs(8, 20); tick(2);
        chk_word("t6_restart", 0, 64'h7766_5544_3322_1100);
        chk("t6_count", obs_b.size(), 8);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                for (int j = 0; j < 4; j++) pool[j] = {$urandom, $urandom};
            end
            capture_en = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) result = pool[$urandom % 4];
            out_ready = (i % 1000 < 300) ? ($urandom % 5 == 0) : ($urandom % 3 != 0);
            rst = ($urandom % 400 == 0);
            tick(1);
        end
        rst = 1'b0; capture_en = 1'b0; out_ready = 1'b1;
        tick(40);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
